bitmap_ram_loader: RTL and testbench

Writer-side counterpart to the 1-bit bitmap ROM used by the LCD path. It accepts a packed byte stream, for example from a UART receiver or SPI-flash reader, over a valid/ready handshake. It unpacks each byte MSB-first into 1-bit pixels and writes them to sequential addresses of an internal 2**ADDR_WIDTH x 1 block RAM. The RAM's read port behaves exactly like the display ROM (registered, 1-cycle latency), so the LCD pixel fetch logic can use this block in place of the ROM and the sign image can be reloaded at runtime.

---
 rtl/bitmap_ram_loader.sv | 101 ++++++++++
 tb/tb_bitmap_ram_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bitmap_ram_loader.sv
// Reloadable 1-bit bitmap RAM: unpacks a valid/ready byte stream MSB-first into
// sequential pixel addresses; the read port mirrors the display ROM (1-cycle latency).
module bitmap_ram_loader #(
    parameter int ADDR_WIDTH   = 17,
    parameter int FRAME_PIXELS = 130560
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  done,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    // One bit wider than the RAM address so a full-depth frame cannot wrap.
    localparam logic [ADDR_WIDTH:0] LAST_PIXEL = (ADDR_WIDTH + 1)'(FRAME_PIXELS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t              state;
    logic [ADDR_WIDTH:0] wr_addr;
    logic [7:0]          shreg;
    logic [2:0]          bitcnt;

    logic mem [DEPTH] = '{default: 1'b0};

    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_addr  <= '0;
            shreg    <= '0;
            bitcnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        wr_addr  <= '0;
                        state    <= LOAD;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (in_valid && in_ready) begin
                        shreg    <= in_data;
                        bitcnt   <= '0;
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                    end
                end
                SHIFT: begin
                    shreg   <= shreg << 1;
                    wr_addr <= wr_addr + 1'b1;
                    bitcnt  <= bitcnt + 1'b1;
                    if (bitcnt == 3'd7) begin
                        if (wr_addr == LAST_PIXEL) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state    <= LOAD;
                            in_ready <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the RAM array has no reset so it maps onto block RAM; the image
    // survives rst and only the initial configuration zeroes it.
    always_ff @(posedge clk) begin
        if (state == SHIFT)
            mem[wr_addr[ADDR_WIDTH-1:0]] <= shreg[7];
    end

    // Same-edge read of the address being written returns the old pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_data <= 1'b0;
        else
            rd_data <= mem[rd_addr];
    end

endmodule

// File: tb/tb_bitmap_ram_loader.sv
// Directed bench for bitmap_ram_loader with a 16-pixel frame in a 32-deep RAM.
module tb_bitmap_ram_loader;

    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic          start;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          busy;
    logic          done;
    logic [AW-1:0] rd_addr;
    logic          rd_data;

    int n_vec  = 0;
    int n_miss = 0;
    int done_cnt = 0;
    int hs_cnt   = 0;

    bitmap_ram_loader #(.ADDR_WIDTH(AW), .FRAME_PIXELS(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs settle 1 time unit after posedge, so negedge sees the values the next edge samples.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (in_valid && in_ready && !rst) hs_cnt++;
    end

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          gap;
        logic [15:0] image;   // bit 15 = address 0
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench just after the handshake edge H.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            step;
            t++;
        end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
        step;
        in_valid = 1'b0;
    endtask

    task automatic wait_ready;
        int t = 0;
        while (!in_ready && t < 50) begin
            step;
            t++;
        end
        if (!in_ready) check("ready_return_timeout", 32'(in_ready), 32'd1);
    endtask

    // Called just after handshake edge H; returns edges until done is seen.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            step;
            lat++;
        end
    endtask

    task automatic read_image(output logic [15:0] img);
        for (int i = 0; i < 16; i++) begin
            rd_addr = AW'(i);
            step;
            img[15-i] = rd_data;
        end
    endtask

    task automatic load_frame(input logic [7:0] b0, input logic [7:0] b1, input int gap,
                              input logic [15:0] exp_img);
        int          d0, h0, lat;
        logic        gap_ok;
        logic [15:0] img;
        d0 = done_cnt;
        h0 = hs_cnt;
        start = 1'b1;
        step;
        start = 1'b0;
        check("ready_after_start", 32'(in_ready), 32'd1);
        check("busy_after_start", 32'(busy), 32'd1);
        send_byte(b0);
        wait_ready;
        if (gap > 0) begin
            gap_ok = 1'b1;
            for (int g = 0; g < gap; g++) begin
                step;
                if (!in_ready) gap_ok = 1'b0;
            end
            check("gap_ready_held", 32'(gap_ok), 32'd1);
            check("gap_wr_addr_hold", 32'(dut.wr_addr), 32'd8);
        end
        send_byte(b1);
        wait_done(lat);
        check("done_latency", 32'(lat), 32'd8);
        check("busy_low_at_done", 32'(busy), 32'd0);
        step;
        check("done_one_cycle", 32'(done), 32'd0);
        check("handshakes", 32'(hs_cnt - h0), 32'd2);
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
        read_image(img);
        check("image", 32'(img), 32'(exp_img));
    endtask

    initial begin
        int          d0, h0, lat;
        logic        seen_ready;
        logic [15:0] img;

        vecs[0] = '{b0: 8'hA5, b1: 8'h3C, gap: 0,  image: 16'hA53C};
        vecs[1] = '{b0: 8'hA5, b1: 8'h3C, gap: 20, image: 16'hA53C};
        vecs[2] = '{b0: 8'hFF, b1: 8'h00, gap: 3,  image: 16'hFF00};
        vecs[3] = '{b0: 8'h00, b1: 8'h00, gap: 0,  image: 16'h0000};

        rst      = 1'b1;
        start    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        rd_addr  = '0;
        #1;
        // Before the first clock edge: async reset alone must clear the outputs.
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        step;
        step;
        rst = 1'b0;
        step;

        for (int v = 0; v < 4; v++)
            load_frame(vecs[v].b0, vecs[v].b1, vecs[v].gap, vecs[v].image);

        // Bytes offered while idle must be refused and leave the RAM alone.
        h0 = hs_cnt;
        seen_ready = 1'b0;
        in_data  = 8'hFF;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step;
            if (in_ready) seen_ready = 1'b1;
        end
        in_valid = 1'b0;
        check("idle_no_ready", 32'(seen_ready), 32'd0);
        check("idle_no_handshake", 32'(hs_cnt - h0), 32'd0);
        read_image(img);
        check("idle_image", 32'(img), 32'h0000);

        // start pulsed during SHIFT is ignored.
        d0 = done_cnt;
        start = 1'b1;
        step;
        start = 1'b0;
        send_byte(8'hC3);
        step;
        step;
        start = 1'b1;
        step;
        start = 1'b0;
        wait_ready;
        send_byte(8'h5A);
        wait_done(lat);
        check("shift_start_done_lat", 32'(lat), 32'd8);
        for (int i = 0; i < 4; i++) step;
        check("shift_start_busy", 32'(busy), 32'd0);
        check("shift_start_ready", 32'(in_ready), 32'd0);
        check("shift_start_pulses", 32'(done_cnt - d0), 32'd1);
        read_image(img);
        check("shift_start_image", 32'(img), 32'hC35A);

        // Reset after the third write of a byte: those three pixels remain.
        start = 1'b1;
        step;
        start = 1'b0;
        send_byte(8'hFF);
        step;
        step;
        step;
        #3;
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_wr_addr", 32'(dut.wr_addr), 32'd0);
        step;
        rst = 1'b0;
        step;
        read_image(img);
        check("midrst_partial_image", 32'(img), 32'hE35A);
        load_frame(8'hFF, 8'hFF, 0, 16'hFFFF);

        // Read-before-write on address 5 while it flips 0 -> 1.
        load_frame(8'h00, 8'h00, 0, 16'h0000);
        rd_addr = AW'(5);
        step;
        step;
        check("coll_pre", 32'(rd_data), 32'd0);
        start = 1'b1;
        step;
        start = 1'b0;
        send_byte(8'h04);
        for (int i = 0; i < 5; i++) step;
        check("coll_before_write", 32'(rd_data), 32'd0);
        step;
        check("coll_write_edge_old", 32'(rd_data), 32'd0);
        step;
        check("coll_next_new", 32'(rd_data), 32'd1);
        wait_ready;
        send_byte(8'h00);
        wait_done(lat);
        check("coll_done_lat", 32'(lat), 32'd8);
        step;
        read_image(img);
        check("coll_image", 32'(img), 32'h0400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
